mini_src_control_unit: RTL and testbench

- Hardwired Moore FSM that sequences the single-bus datapath through fetch, decode and execute of each instruction.
- Drives the register select/encode lines (Gra/Grb/Grc, Rin, Rout, BAout), the bus source/destination strobes, the ALU op and the memory handshake.
- Sits beside the datapath: reads IR and the branch condition flag, and writes no data itself.

---
 rtl/mini_src_control_unit.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_mini_src_control_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_src_control_unit.sv
// Hardwired control sequencer for the single-bus mini SRC datapath.
// Moore FSM stepping fetch/decode/execute with bounded memory waits.
`timescale 1ns/1ps
module mini_src_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic        con_ff,
   input  logic        mem_ack,
   output logic [3:0]  Gra,
   output logic [3:0]  Grb,
   output logic [3:0]  Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        con_in,
   output logic        Read,
   output logic        Write,
   output logic [3:0]  alu_op,
   output logic        run,
   output logic        illegal,
   output logic        mem_err,
   output logic [2:0]  step
);

   typedef enum logic [3:0] {
      ST_RST, ST_T0, ST_T1, ST_T2, ST_T3,
      ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b00111;
   localparam logic [4:0] OP_ANDI = 5'b01000;
   localparam logic [4:0] OP_ORI  = 5'b01001;
   localparam logic [4:0] OP_BR   = 5'b01010;
   localparam logic [4:0] OP_JR   = 5'b01011;
   localparam logic [4:0] OP_NOP  = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11001;

   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   state_t     state_n;
   logic [7:0] wcnt;
   logic [4:0] op;
   logic       op_ld, op_ldi, op_st, op_br, op_jr;
   logic       op_nop, op_halt, op_alu3, op_imm;
   logic       op_mem, op_legal;
   logic [3:0] alu_sel;
   logic       in_wait;
   logic       timeout;
   logic       ga, gb, gc;
   logic       unused_ir;

   // Register fields are decoded by the datapath, not here.
   assign unused_ir = ^ir[26:0];

   assign op      = ir[31:27];
   assign op_ld   = (op == OP_LD);
   assign op_ldi  = (op == OP_LDI);
   assign op_st   = (op == OP_ST);
   assign op_br   = (op == OP_BR);
   assign op_jr   = (op == OP_JR);
   assign op_nop  = (op == OP_NOP);
   assign op_halt = (op == OP_HALT);
   assign op_alu3 = (op >= OP_ADD) && (op <= OP_OR);
   assign op_imm  = (op >= OP_ADDI) && (op <= OP_ORI);
   assign op_mem  = op_ld || op_ldi || op_st;
   assign op_legal = op_mem || op_alu3 || op_imm || op_br
                  || op_jr || op_nop || op_halt;

   always_comb begin
      alu_sel = ALU_NONE;
      unique case (1'b1)
         (op == OP_ADD) || (op == OP_ADDI): alu_sel = ALU_ADD;
         (op == OP_SUB):                    alu_sel = ALU_SUB;
         (op == OP_AND) || (op == OP_ANDI): alu_sel = ALU_AND;
         (op == OP_OR)  || (op == OP_ORI):  alu_sel = ALU_OR;
         default:                           alu_sel = ALU_NONE;
      endcase
   end

   assign in_wait = (state == ST_T1)
                 || ((state == ST_T6) && op_ld)
                 || ((state == ST_T7) && op_st);
   assign timeout = in_wait && !mem_ack && (wcnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_RST;
      else       state <= state_n;
   end

   // Counter is zero outside wait states, so it starts clean on entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt    <= '0;
         mem_err <= 1'b0;
      end else begin
         if (in_wait && !mem_ack && !timeout) wcnt <= wcnt + 8'd1;
         else                                 wcnt <= '0;
         if (timeout) mem_err <= 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_RST: state_n = ST_T0;
         ST_T0:  state_n = ST_T1;
         ST_T1: begin
            if (mem_ack)      state_n = ST_T2;
            else if (timeout) state_n = ST_HALT;
         end
         ST_T2:  state_n = ST_T3;
         ST_T3: begin
            if (op_halt)
               state_n = ST_HALT;
            else if (op_jr || op_nop || !op_legal)
               state_n = ST_T0;
            else
               state_n = ST_T4;
         end
         ST_T4:  state_n = ST_T5;
         ST_T5: begin
            if (op_ld || op_st || op_br) state_n = ST_T6;
            else                         state_n = ST_T0;
         end
         ST_T6: begin
            if (op_ld) begin
               if (mem_ack)      state_n = ST_T7;
               else if (timeout) state_n = ST_HALT;
            end else if (op_st) begin
               state_n = ST_T7;
            end else begin
               state_n = ST_T0;
            end
         end
         ST_T7: begin
            if (op_st) begin
               if (mem_ack)      state_n = ST_T0;
               else if (timeout) state_n = ST_HALT;
            end else begin
               state_n = ST_T0;
            end
         end
         ST_HALT: state_n = ST_HALT;
         default: state_n = ST_RST;
      endcase
   end

   always_comb begin
      ga = 1'b0; gb = 1'b0; gc = 1'b0;
      Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
      MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
      Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; con_in = 1'b0;
      Read = 1'b0; Write = 1'b0;
      alu_op = ALU_NONE;
      run = 1'b0; illegal = 1'b0; step = 3'd0;
      case (state)
         ST_T0: begin
            run = 1'b1; step = 3'd0;
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
         end
         ST_T1: begin
            run = 1'b1; step = 3'd1;
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         ST_T2: begin
            run = 1'b1; step = 3'd2;
            MDRout = 1'b1; IRin = 1'b1;
         end
         ST_T3: begin
            run = 1'b1; step = 3'd3;
            unique case (1'b1)
               op_mem: begin
                  gb = 1'b1; BAout = 1'b1; Yin = 1'b1;
               end
               op_alu3 || op_imm: begin
                  gb = 1'b1; Rout = 1'b1; Yin = 1'b1;
               end
               op_br: begin
                  ga = 1'b1; Rout = 1'b1; con_in = 1'b1;
               end
               op_jr: begin
                  ga = 1'b1; Rout = 1'b1; PCin = 1'b1;
               end
               !op_legal: illegal = 1'b1;
               default: ;
            endcase
         end
         ST_T4: begin
            run = 1'b1; step = 3'd4;
            unique case (1'b1)
               op_mem: begin
                  Cout = 1'b1; alu_op = ALU_ADD; Zin = 1'b1;
               end
               op_alu3: begin
                  gc = 1'b1; Rout = 1'b1; alu_op = alu_sel; Zin = 1'b1;
               end
               op_imm: begin
                  Cout = 1'b1; alu_op = alu_sel; Zin = 1'b1;
               end
               op_br: begin
                  PCout = 1'b1; Yin = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            run = 1'b1; step = 3'd5;
            unique case (1'b1)
               op_ld || op_st: begin
                  Zlowout = 1'b1; MARin = 1'b1;
               end
               op_ldi || op_alu3 || op_imm: begin
                  Zlowout = 1'b1; ga = 1'b1; Rin = 1'b1;
               end
               op_br: begin
                  Cout = 1'b1; alu_op = ALU_ADD; Zin = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            run = 1'b1; step = 3'd6;
            unique case (1'b1)
               op_ld: begin
                  Read = 1'b1; MDRin = 1'b1;
               end
               op_st: begin
                  ga = 1'b1; Rout = 1'b1; MDRin = 1'b1;
               end
               op_br: begin
                  Zlowout = con_ff; PCin = con_ff;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            run = 1'b1; step = 3'd7;
            unique case (1'b1)
               op_ld: begin
                  MDRout = 1'b1; ga = 1'b1; Rin = 1'b1;
               end
               op_st: Write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign Gra = {4{ga}};
   assign Grb = {4{gb}};
   assign Grc = {4{gc}};

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Randomized self-checking bench for mini_src_control_unit.
// Expected strobes come from a per-instruction step table model.
`timescale 1ns/1ps
module tb_mini_src_control_unit;

   localparam int TO = 15;
   localparam int LEGAL[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 24};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ir = '0;
   logic        con_ff = 1'b0;
   logic        mem_ack = 1'b0;
   logic [3:0]  Gra, Grb, Grc;
   logic        Rin, Rout, BAout, Cout;
   logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
   logic        Yin, Zin, Zlowout, con_in, Read, Write;
   logic [3:0]  alu_op;
   logic        run, illegal, mem_err;
   logic [2:0]  step;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mini_src_control_unit #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff),
      .mem_ack(mem_ack),
      .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
      .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .con_in(con_in),
      .Read(Read), .Write(Write), .alu_op(alu_op),
      .run(run), .illegal(illegal), .mem_err(mem_err), .step(step)
   );

   typedef struct packed {
      logic [3:0] ga, gb, gc;
      logic rin, rout, baout, cout, pcout, pcin, incpc, marin;
      logic mdrin, mdrout, irin, yin, zin, zlow, conin, rd, wr;
      logic [3:0] alu;
      logic run, ill, merr;
      logic [2:0] step;
   } ctl_t;

   function automatic ctl_t observed();
      ctl_t o;
      o.ga = Gra; o.gb = Grb; o.gc = Grc;
      o.rin = Rin; o.rout = Rout; o.baout = BAout; o.cout = Cout;
      o.pcout = PCout; o.pcin = PCin; o.incpc = IncPC; o.marin = MARin;
      o.mdrin = MDRin; o.mdrout = MDRout; o.irin = IRin; o.yin = Yin;
      o.zin = Zin; o.zlow = Zlowout; o.conin = con_in;
      o.rd = Read; o.wr = Write; o.alu = alu_op;
      o.run = run; o.ill = illegal; o.merr = mem_err; o.step = step;
      return o;
   endfunction

   function automatic bit is_legal(input int op);
      return (op <= 11) || (op == 24) || (op == 25);
   endfunction

   function automatic logic [3:0] alu_code(input int op);
      case (op)
         3, 7:    return 4'd1;
         4:       return 4'd2;
         5, 8:    return 4'd3;
         6, 9:    return 4'd4;
         default: return 4'd0;
      endcase
   endfunction

   function automatic int n_steps(input int op);
      case (op)
         0, 2:    return 8;
         1, 3, 4, 5, 6, 7, 8, 9: return 6;
         10:      return 7;
         default: return 4;
      endcase
   endfunction

   function automatic bit is_wait(input int op, input int t);
      return (t == 1) || (t == 6 && op == 0) || (t == 7 && op == 2);
   endfunction

   // Instruction table: which strobes each opcode class raises at step t.
   function automatic ctl_t expect_word(input int op, input int t,
                                        input logic con);
      ctl_t w = '0;
      w.run = 1'b1;
      w.step = 3'(t);
      case (t)
         0: begin w.pcout = 1; w.marin = 1; w.incpc = 1; w.zin = 1; end
         1: begin w.zlow = 1; w.pcin = 1; w.rd = 1; w.mdrin = 1; end
         2: begin w.mdrout = 1; w.irin = 1; end
         3: begin
            if (op <= 2) begin
               w.gb = 4'hF; w.baout = 1; w.yin = 1;
            end else if (op <= 9) begin
               w.gb = 4'hF; w.rout = 1; w.yin = 1;
            end else if (op == 10) begin
               w.ga = 4'hF; w.rout = 1; w.conin = 1;
            end else if (op == 11) begin
               w.ga = 4'hF; w.rout = 1; w.pcin = 1;
            end else if (!is_legal(op)) begin
               w.ill = 1;
            end
         end
         4: begin
            if (op <= 2) begin
               w.cout = 1; w.alu = 4'd1; w.zin = 1;
            end else if (op <= 6) begin
               w.gc = 4'hF; w.rout = 1; w.alu = alu_code(op); w.zin = 1;
            end else if (op <= 9) begin
               w.cout = 1; w.alu = alu_code(op); w.zin = 1;
            end else if (op == 10) begin
               w.pcout = 1; w.yin = 1;
            end
         end
         5: begin
            if (op == 0 || op == 2) begin
               w.zlow = 1; w.marin = 1;
            end else if (op <= 9) begin
               w.zlow = 1; w.ga = 4'hF; w.rin = 1;
            end else if (op == 10) begin
               w.cout = 1; w.alu = 4'd1; w.zin = 1;
            end
         end
         6: begin
            if (op == 0) begin
               w.rd = 1; w.mdrin = 1;
            end else if (op == 2) begin
               w.ga = 4'hF; w.rout = 1; w.mdrin = 1;
            end else if (op == 10 && con) begin
               w.zlow = 1; w.pcin = 1;
            end
         end
         7: begin
            if (op == 0) begin
               w.mdrout = 1; w.ga = 4'hF; w.rin = 1;
            end else if (op == 2) begin
               w.wr = 1;
            end
         end
         default: ;
      endcase
      return w;
   endfunction

   // Runs one instruction from T0, checking every cycle; ends at the next T0/HALT.
   task automatic exec_instr(input string tag, input int op,
                             input logic con, input int dly,
                             input logic [26:0] low);
      ctl_t e, a;
      int last;
      ir = {5'(op), low};
      con_ff = con;
      for (int t = 0; t < n_steps(op); t++) begin
         last = is_wait(op, t) ? dly : 0;
         for (int k = 0; k <= last; k++) begin
            if (is_wait(op, t)) mem_ack = (k == last);
            else                mem_ack = 1'($urandom);
            e = expect_word(op, t, con);
            a = observed();
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL %s op=%0d T%0d wait%0d: got %h want %h",
                        tag, op, t, k, a, e);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      ctl_t a;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      a = observed();
      n_tests++;
      if (a !== ctl_t'(0)) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", a, ctl_t'(0));
      end
      reset = 1'b0;
      @(posedge clk); #1;
      a = observed();
      n_tests++;
      if (a !== expect_word(0, 0, 1'b0)) begin
         n_fail++;
         $display("FAIL reset_to_t0: got %h want %h", a,
                  expect_word(0, 0, 1'b0));
      end
   endtask

   task automatic test_add();
      exec_instr("add", 3, 1'b0, 0, 27'h0918000);
   endtask

   task automatic test_ld_wait();
      exec_instr("ld_wait3", 0, 1'b0, 3, 27'($urandom));
   endtask

   task automatic test_br();
      exec_instr("br_con0", 10, 1'b0, 0, 27'($urandom));
      exec_instr("br_con1", 10, 1'b1, 0, 27'($urandom));
   endtask

   task automatic test_illegal();
      ctl_t a;
      exec_instr("illegal", 31, 1'b0, 0, 27'($urandom));
      a = observed();
      n_tests++;
      if (a !== expect_word(0, 0, 1'b0)) begin
         n_fail++;
         $display("FAIL illegal_return: got %h want %h", a,
                  expect_word(0, 0, 1'b0));
      end
   endtask

   task automatic test_random();
      int op;
      for (int i = 0; i < 40; i++) begin
         if ($urandom % 4 == 0)
            op = ($urandom % 2 == 0) ? 12 + int'($urandom % 12)
                                     : 26 + int'($urandom % 6);
         else
            op = LEGAL[$urandom % 13];
         exec_instr("random", op, 1'($urandom),
                    int'($urandom_range(0, 5)), 27'($urandom));
      end
   endtask

   task automatic test_reset_mid();
      ctl_t a;
      ir = {5'd2, 27'($urandom)};
      con_ff = 1'b0;
      for (int t = 0; t <= 4; t++) begin
         mem_ack = 1'b1;
         a = observed();
         n_tests++;
         if (a !== expect_word(2, t, 1'b0)) begin
            n_fail++;
            $display("FAIL st_pre_reset T%0d: got %h want %h", t, a,
                     expect_word(2, t, 1'b0));
         end
         if (t < 4) begin
            @(posedge clk); #1;
         end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      a = observed();
      n_tests++;
      if (a !== ctl_t'(0)) begin
         n_fail++;
         $display("FAIL st_in_reset: got %h want %h", a, ctl_t'(0));
      end
      reset = 1'b0;
      @(posedge clk); #1;
      a = observed();
      n_tests++;
      if (a !== expect_word(0, 0, 1'b0)) begin
         n_fail++;
         $display("FAIL st_refetch: got %h want %h", a,
                  expect_word(0, 0, 1'b0));
      end
   endtask

   task automatic test_timeout();
      ctl_t a, e;
      ir = {5'd24, 27'($urandom)};
      mem_ack = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < TO; i++) begin
         mem_ack = 1'b0;
         a = observed();
         n_tests++;
         if (a !== expect_word(24, 1, 1'b0)) begin
            n_fail++;
            $display("FAIL timeout_wait%0d: got %h want %h", i, a,
                     expect_word(24, 1, 1'b0));
         end
         @(posedge clk); #1;
      end
      e = '0;
      e.merr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mem_ack = 1'b1;
         a = observed();
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL timeout_halt%0d: got %h want %h", i, a, e);
         end
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      a = observed();
      n_tests++;
      if (a !== ctl_t'(0)) begin
         n_fail++;
         $display("FAIL timeout_clear: got %h want %h", a, ctl_t'(0));
      end
      reset = 1'b0;
      @(posedge clk); #1;
      a = observed();
      n_tests++;
      if (a !== expect_word(0, 0, 1'b0)) begin
         n_fail++;
         $display("FAIL timeout_restart: got %h want %h", a,
                  expect_word(0, 0, 1'b0));
      end
   endtask

   task automatic test_halt();
      ctl_t a;
      exec_instr("halt", 25, 1'b0, 0, 27'($urandom));
      for (int i = 0; i < 22; i++) begin
         mem_ack = 1'($urandom);
         a = observed();
         n_tests++;
         if (a !== ctl_t'(0)) begin
            n_fail++;
            $display("FAIL halt_hold%0d: got %h want %h", i, a, ctl_t'(0));
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_ld_wait();
      test_br();
      test_illegal();
      test_random();
      test_reset_mid();
      test_timeout();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
